// File: rtl/timer_pkg.sv
// Shared definitions for the carry-save countdown timer: FSM encoding and the
// legal delay window, which depends on the counter width.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_e;

   // Shortest delay is one full carry ripple through the skewed counter.
   function automatic int nb_min(input int w);
      return w;
   endfunction

   function automatic int nb_max(input int w);
      return 1 << (w - 1);
   endfunction

   function automatic logic nb_ok(input int n, input int w);
      return (n >= nb_min(w)) && (n <= nb_max(w));
   endfunction

endpackage

// File: rtl/compressor2.sv
// 2:2 compressor row (half adders): one carry-save advance step, no carry chain.
module compressor2 #(
   parameter int width = 4
) (
   input  logic [width-1:0] a_i,
   input  logic [width-1:0] b_i,
   output logic [width-1:0] s_o,
   output logic [width-1:0] c_o
);

   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;

endmodule

// File: rtl/timer.sv
// Countdown timer built on a carry-save incrementer; expiry is the carry out of
// the top bit, so no carry-propagate adder sits on the count path.
module timer
   import timer_pkg::*;
#(
   parameter int width = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ld,
   input  logic [width-1:0] nb,
   input  logic             per,
   input  logic             en,
   output logic             dn,
   output logic             tick,
   output logic             busy,
   output logic             err
);

   // Bit i of the sum lags the true count by i cycles, so the top carry fires
   // width-1 advances late; preloading -(N-width+1) makes it land on advance N-1.
   localparam logic [width-1:0] PRE_OFS = width'(width - 1);

   state_e             st_q, st_d;
   logic [width-1:0]   sum_q, sum_d;
   logic [width-2:0]   cry_q, cry_d;
   logic [width-1:0]   n_q, n_d;
   logic               per_q, per_d;
   logic               err_q, err_d;

   logic [width-2:0]   cs_s, cs_c;
   logic [width-1:0]   cy_full;
   logic               top_c, ld_ok, running, step, expire, reload;

   // Bit 0 always adds the implicit +1, so only bits 1..width-1 need compressors.
   compressor2 #(.width(width - 1)) u_cs (
      .a_i (sum_q[width-1:1]),
      .b_i (cry_q),
      .s_o (cs_s),
      .c_o (cs_c)
   );

   assign cy_full = {cs_c, sum_q[0]};
   assign top_c   = cy_full[width-1];

   assign ld_ok   = ld & nb_ok(32'(nb), width);
   assign running = (st_q == RUN);
   assign step    = running & en;
   assign expire  = step & top_c & ~ld_ok & ~rst;
   assign reload  = expire & per_q;

   assign st_d  = ld_ok               ? RUN  :
                  (expire & ~per_q)   ? DONE : st_q;
   assign sum_d = ld_ok  ? PRE_OFS - nb  :
                  reload ? PRE_OFS - n_q :
                  step   ? {cs_s, ~sum_q[0]} : sum_q;
   assign cry_d = (ld_ok | reload) ? '0 :
                  step             ? cy_full[width-2:0] : cry_q;
   assign n_d   = ld_ok ? nb  : n_q;
   assign per_d = ld_ok ? per : per_q;
   assign err_d = ld & ~ld_ok;

   assign tick = expire;
   assign dn   = (st_q == DONE) | (expire & ~per_q);
   assign busy = running;
   assign err  = err_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q  <= IDLE;
         sum_q <= '0;
         cry_q <= '0;
         n_q   <= '0;
         per_q <= 1'b0;
         err_q <= 1'b0;
      end else begin
         st_q  <= st_d;
         sum_q <= sum_d;
         cry_q <= cry_d;
         n_q   <= n_d;
         per_q <= per_d;
         err_q <= err_d;
      end
   end

endmodule

// File: tb/tb_timer.sv
// Self-checking bench for timer: a decrementing reference model predicts each
// cycle's outputs into a scoreboard queue that is drained at the falling edge.
module tb_timer;

   localparam int W = 5;

   logic         clk = 1'b0;
   logic         rst, ld, per, en;
   logic [W-1:0] nb;
   logic         dn, tick, busy, err;

   timer #(.width(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .ld   (ld),
      .nb   (nb),
      .per  (per),
      .en   (en),
      .dn   (dn),
      .tick (tick),
      .busy (busy),
      .err  (err)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic dn;
      logic tick;
      logic busy;
      logic err;
   } exp_t;

   exp_t sb[$];
   int   ticks[$];
   int   n_chk = 0;
   int   n_err = 0;
   int   t_rel = 0;

   // reference model: remaining enabled cycles until expiry
   int   m_st = 0;
   int   m_rem = 0;
   int   m_n = 0;
   logic m_per = 1'b0;
   logic m_err = 1'b0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0d exp %0d", tag, got, exp);
      end
   endtask

   function automatic int tick_at(input int i);
      return (ticks.size() > i) ? ticks[i] : -1;
   endfunction

   task automatic cyc(input logic r, input logic l, input int n, input logic p, input logic e);
      exp_t x;
      logic ok;
      t_rel++;
      rst = r; ld = l; nb = W'(n); per = p; en = e;
      ok = l && (n >= W) && (n <= (1 << (W - 1)));
      x.busy = (m_st == 1);
      x.tick = (m_st == 1) && e && (m_rem == 1) && !ok && !r;
      x.dn   = (m_st == 2) || (x.tick && !m_per);
      x.err  = m_err;
      sb.push_back(x);
      @(negedge clk);
      x = sb.pop_front();
      chk($sformatf("dn@%0d", t_rel), 32'(dn), 32'(x.dn));
      chk($sformatf("tick@%0d", t_rel), 32'(tick), 32'(x.tick));
      chk($sformatf("busy@%0d", t_rel), 32'(busy), 32'(x.busy));
      chk($sformatf("err@%0d", t_rel), 32'(err), 32'(x.err));
      if (tick === 1'b1) ticks.push_back(t_rel);
      @(posedge clk);
      if (r) begin
         m_st = 0; m_rem = 0; m_n = 0; m_per = 1'b0; m_err = 1'b0;
      end else begin
         m_err = l && !ok;
         if (ok) begin
            m_st = 1; m_rem = n; m_n = n; m_per = p;
         end else if (m_st == 1 && e) begin
            if (m_rem == 1) begin
               if (m_per) m_rem = m_n;
               else m_st = 2;
            end else begin
               m_rem--;
            end
         end
      end
      #1;
   endtask

   task automatic load(input int n, input logic p);
      cyc(1'b0, 1'b1, n, p, 1'b1);
      t_rel = 0;
      ticks.delete();
   endtask

   task automatic run(input int k, input logic p, input logic e);
      for (int i = 0; i < k; i++) cyc(1'b0, 1'b0, 0, p, e);
   endtask

   initial begin
      rst = 1'b1; ld = 1'b0; nb = '0; per = 1'b0; en = 1'b0;
      @(posedge clk); #1;
      cyc(1'b1, 1'b1, 10, 1'b1, 1'b1);
      chk("rst_dn", 32'(dn), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_err", 32'(err), 0);
      run(3, 1'b0, 1'b1);

      // one-shot N=10
      load(10, 1'b0);
      run(14, 1'b1, 1'b1);
      chk("A_ntick", ticks.size(), 1);
      chk("A_tick_at", tick_at(0), 10);
      chk("A_dn_held", 32'(dn), 1);
      chk("A_busy_low", 32'(busy), 0);

      // range boundaries
      load(5, 1'b0);
      run(7, 1'b0, 1'b1);
      chk("Bmin_tick_at", tick_at(0), 5);
      load(16, 1'b0);
      run(18, 1'b0, 1'b1);
      chk("Bmax_tick_at", tick_at(0), 16);

      // periodic N=7; per input changes without ld must not matter
      load(7, 1'b1);
      run(22, 1'b0, 1'b1);
      chk("P_ntick", ticks.size(), 3);
      chk("P_tick0", tick_at(0), 7);
      chk("P_tick1", tick_at(1), 14);
      chk("P_tick2", tick_at(2), 21);
      chk("P_dn_low", 32'(dn), 0);
      chk("P_busy", 32'(busy), 1);

      // pause: en low for cycles 4..6
      load(10, 1'b0);
      run(3, 1'b0, 1'b1);
      run(3, 1'b0, 1'b0);
      run(10, 1'b0, 1'b1);
      chk("C_ntick", ticks.size(), 1);
      chk("C_tick_at", tick_at(0), 13);

      // abort: reload N=6 at cycle 9
      load(10, 1'b0);
      run(8, 1'b0, 1'b1);
      load(6, 1'b0);
      chk("D_aborted", ticks.size(), 0);
      run(8, 1'b0, 1'b1);
      chk("D_ntick", ticks.size(), 1);
      chk("D_tick_at", tick_at(0), 6);

      // abort on the very expiry cycle
      load(5, 1'b0);
      run(4, 1'b0, 1'b1);
      load(8, 1'b0);
      run(10, 1'b0, 1'b1);
      chk("D2_tick_at", tick_at(0), 8);

      // out-of-range loads in DONE and RUN
      cyc(1'b0, 1'b1, 3, 1'b0, 1'b1);
      chk("E_err_lo", 32'(err), 1);
      chk("E_dn_kept", 32'(dn), 1);
      cyc(1'b0, 1'b1, 4, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 0, 1'b0, 1'b1);
      chk("E_err_pulse", 32'(err), 0);
      load(8, 1'b0);
      run(2, 1'b0, 1'b1);
      cyc(1'b0, 1'b1, 17, 1'b1, 1'b1);
      run(7, 1'b0, 1'b1);
      chk("E_run_tick_at", tick_at(0), 8);

      // reset with ld at cycle 5
      load(10, 1'b0);
      run(4, 1'b0, 1'b1);
      cyc(1'b1, 1'b1, 6, 1'b0, 1'b1);
      run(12, 1'b0, 1'b1);
      chk("F_ntick", ticks.size(), 0);
      chk("F_busy", 32'(busy), 0);
      chk("F_dn", 32'(dn), 0);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
